// File: rtl/alu_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_seq_pkg : opcodes, sequencer states and ALU control-bit constants.     |
// | Option macro: ALU_SEQ_MUL_EN adds the shift-add multiply states.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ZERO = 4'd0,
    OP_ONE  = 4'd1,
    OP_NEG1 = 4'd2,
    OP_X    = 4'd3,
    OP_Y    = 4'd4,
    OP_NOTX = 4'd5,
    OP_NOTY = 4'd6,
    OP_NEGX = 4'd7,
    OP_ADD  = 4'd8,
    OP_SUB  = 4'd9,
    OP_AND  = 4'd10,
    OP_OR   = 4'd11,
    OP_MUL  = 4'd12
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_DONE    = 3'd2
`ifdef ALU_SEQ_MUL_EN
    ,
    ST_MUL_ADD = 3'd3,
    ST_MUL_DBL = 3'd4
`endif
  } state_e;

  // Control-bit order is {zx, nx, zy, ny, f, no}.
  localparam logic [5:0] c_ctrl_zero = 6'b101010;
  localparam logic [5:0] c_ctrl_one  = 6'b111111;
  localparam logic [5:0] c_ctrl_neg1 = 6'b111010;
  localparam logic [5:0] c_ctrl_x    = 6'b001100;
  localparam logic [5:0] c_ctrl_y    = 6'b110000;
  localparam logic [5:0] c_ctrl_notx = 6'b001101;
  localparam logic [5:0] c_ctrl_noty = 6'b110001;
  localparam logic [5:0] c_ctrl_negx = 6'b001111;
  localparam logic [5:0] c_ctrl_add  = 6'b000010;
  localparam logic [5:0] c_ctrl_sub  = 6'b010011;
  localparam logic [5:0] c_ctrl_and  = 6'b000000;
  localparam logic [5:0] c_ctrl_or   = 6'b010101;

endpackage

`default_nettype wire

// File: rtl/alu_seq_decode.sv
// +----------------------------------------------------------------------------+
// | alu_seq_decode : combinational opcode to ALU control-bit decoder.          |
// | Option macro   : ALU_SEQ_MUL_EN makes opcode 12 legal (ADD bits).          |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] i_op,
  output logic [5:0] o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = c_ctrl_zero;
    o_illegal = 1'b0;
    case (i_op)
      OP_ZERO: o_ctrl = c_ctrl_zero;
      OP_ONE:  o_ctrl = c_ctrl_one;
      OP_NEG1: o_ctrl = c_ctrl_neg1;
      OP_X:    o_ctrl = c_ctrl_x;
      OP_Y:    o_ctrl = c_ctrl_y;
      OP_NOTX: o_ctrl = c_ctrl_notx;
      OP_NOTY: o_ctrl = c_ctrl_noty;
      OP_NEGX: o_ctrl = c_ctrl_negx;
      OP_ADD:  o_ctrl = c_ctrl_add;
      OP_SUB:  o_ctrl = c_ctrl_sub;
      OP_AND:  o_ctrl = c_ctrl_and;
      OP_OR:   o_ctrl = c_ctrl_or;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  o_ctrl = c_ctrl_add;
`endif
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// +----------------------------------------------------------------------------+
// | alu_sequencer : request/response sequencer around an external Hack ALU.    |
// | Option macro  : ALU_SEQ_MUL_EN enables 16-step shift-add multiply (op 12). |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zr,
  output logic             rsp_ng,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  state_e           r_state;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zr;
  logic             r_rsp_ng;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [5:0]       r_ctrl;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [3:0]       r_iter;
`endif

  logic [5:0]       w_dec_ctrl;
  logic             w_dec_illegal;
  logic [WIDTH-1:0] w_alu_x;
  logic [WIDTH-1:0] w_alu_y;
  logic [5:0]       w_ctrl;

  alu_seq_decode u_decode (
    .i_op      (req_op),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal)
  );

  // The ALU is combinational, so its inputs follow the state directly; reset
  // overrides everything to zero without waiting for a clock.
  always_comb begin
    w_alu_x = '0;
    w_alu_y = '0;
    w_ctrl  = c_ctrl_zero;
    case (r_state)
      ST_EXEC: begin
        w_alu_x = r_x;
        w_alu_y = r_y;
        w_ctrl  = r_ctrl;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL_ADD: begin
        w_alu_x = r_acc;
        w_alu_y = r_mcand;
        w_ctrl  = c_ctrl_add;
      end
      ST_MUL_DBL: begin
        w_alu_x = r_mcand;
        w_alu_y = r_mcand;
        w_ctrl  = c_ctrl_add;
      end
`endif
      default: ;
    endcase
    if (rst) begin
      w_alu_x = '0;
      w_alu_y = '0;
      w_ctrl  = 6'b000000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zr    <= 1'b0;
      r_rsp_ng    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_ctrl      <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_iter      <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_x         <= req_x;
            r_y         <= req_y;
            r_ctrl      <= w_dec_ctrl;
            if (w_dec_illegal) begin
              r_state    <= ST_DONE;
              r_rsp_data <= '0;
              r_rsp_zr   <= 1'b1;
              r_rsp_ng   <= 1'b0;
              r_rsp_err  <= 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (req_op == OP_MUL) begin
              r_state  <= ST_MUL_ADD;
              r_acc    <= '0;
              r_mcand  <= req_x;
              r_mplier <= req_y;
              r_iter   <= '0;
            end
`endif
            else begin
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_state    <= ST_DONE;
          r_rsp_data <= alu_out;
          r_rsp_zr   <= (alu_out == '0);
          r_rsp_ng   <= alu_out[WIDTH-1];
          r_rsp_err  <= 1'b0;
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL_ADD: begin
          if (r_mplier[0]) begin
            r_acc <= alu_out;
          end
          r_state <= ST_MUL_DBL;
        end
        ST_MUL_DBL: begin
          r_mcand  <= alu_out;
          r_mplier <= r_mplier >> 1;
          r_iter   <= r_iter + 4'd1;
          if (r_iter == 4'd15) begin
            r_state    <= ST_DONE;
            r_rsp_data <= r_acc;
            r_rsp_zr   <= (r_acc == '0);
            r_rsp_ng   <= r_acc[WIDTH-1];
            r_rsp_err  <= 1'b0;
          end else begin
            r_state <= ST_MUL_ADD;
          end
        end
`endif
        ST_DONE: begin
          // First DONE cycle only raises rsp_valid; the result is already held.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zr    <= 1'b0;
            r_rsp_ng    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zr    = r_rsp_zr;
  assign rsp_ng    = r_rsp_ng;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE);
  assign alu_x     = w_alu_x;
  assign alu_y     = w_alu_y;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = w_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_alu_sequencer : bench with an external Hack ALU and arithmetic model.   |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [15:0] req_x = 16'd0;
  logic [15:0] req_y = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_zr, rsp_ng, rsp_err;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic        busy;
  logic [15:0] tb_a, tb_b, tb_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .rsp_err(rsp_err),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .busy(busy)
  );

  // External combinational Hack ALU.
  always_comb begin
    tb_a = alu_zx ? 16'h0000 : alu_x;
    if (alu_nx) tb_a = ~tb_a;
    tb_b = alu_zy ? 16'h0000 : alu_y;
    if (alu_ny) tb_b = ~tb_b;
    tb_o = alu_f ? (tb_a + tb_b) : (tb_a & tb_b);
    if (alu_no) tb_o = ~tb_o;
    alu_out = tb_o;
  end

  // Reference: {err, data} from the plain arithmetic meaning of each opcode.
  function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    logic [16:0] r;
    p = 32'(x) * 32'(y);
    r = 17'd0;
    case (op)
      4'd0:  r = {1'b0, 16'h0000};
      4'd1:  r = {1'b0, 16'h0001};
      4'd2:  r = {1'b0, 16'hFFFF};
      4'd3:  r = {1'b0, x};
      4'd4:  r = {1'b0, y};
      4'd5:  r = {1'b0, ~x};
      4'd6:  r = {1'b0, ~y};
      4'd7:  r = {1'b0, 16'h0000 - x};
      4'd8:  r = {1'b0, x + y};
      4'd9:  r = {1'b0, x - y};
      4'd10: r = {1'b0, x & y};
      4'd11: r = {1'b0, x | y};
`ifdef ALU_SEQ_MUL_EN
      4'd12: r = {1'b0, p[15:0]};
`endif
      default: r = {1'b1, 16'h0000};
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic err);
    if (err) return 1;
    if (op == 4'd12) return 33;
    return 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] ed, input logic ee, input int elat, input bit do_ack);
    int n;
    @(negedge clk);
    chk("req_ready before request", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy after accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, elat);
    chk("rsp_data", {16'd0, rsp_data}, {16'd0, ed});
    chk("rsp_zr", {31'd0, rsp_zr}, {31'd0, (ed == 16'h0000)});
    chk("rsp_ng", {31'd0, rsp_ng}, {31'd0, ed[15]});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
    if (do_ack) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_valid after ack", {31'd0, rsp_valid}, 32'd0);
      chk("req_ready after ack", {31'd0, req_ready}, 32'd1);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] m;
    logic [3:0]  rop;
    logic [15:0] rx, ry;

    tbl[0] = '{4'd8,  16'h0003, 16'h0004, 16'h0007, 1'b0, 2};
    tbl[1] = '{4'd9,  16'h0005, 16'h0005, 16'h0000, 1'b0, 2};
    tbl[2] = '{4'd7,  16'h0001, 16'h0000, 16'hFFFF, 1'b0, 2};
    tbl[3] = '{4'd15, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1};
`ifdef ALU_SEQ_MUL_EN
    tbl[4] = '{4'd12, 16'h0007, 16'h0006, 16'h002A, 1'b0, 33};
    tbl[5] = '{4'd12, 16'h8000, 16'h0002, 16'h0000, 1'b0, 33};
`else
    tbl[4] = '{4'd12, 16'h0007, 16'h0006, 16'h0000, 1'b1, 1};
    tbl[5] = '{4'd12, 16'h8000, 16'h0002, 16'h0000, 1'b1, 1};
`endif
    tbl[6] = '{4'd1,  16'hAAAA, 16'h5555, 16'h0001, 1'b0, 2};
    tbl[7] = '{4'd10, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 2};

    // Reset state
    #12;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("reset alu ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle alu ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'b101010);
    chk("idle alu_x", {16'd0, alu_x}, 32'd0);

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].e, tbl[i].lat, 1'b1);

    // Result held while the consumer stalls; a request during the ack is ignored.
    run_op(4'd11, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall rsp_data", {16'd0, rsp_data}, 32'h0FF0);
      chk("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b1; req_op = 4'd8; req_x = 16'd1; req_y = 16'd1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("no accept on ack edge", {31'd0, busy}, 32'd0);
    chk("req_ready after ack edge", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;

    // Reset pulsed mid-operation discards it.
    @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
    req_op = 4'd12;
`else
    req_op = 4'd8;
`endif
    req_valid = 1'b1; req_x = 16'h0007; req_y = 16'h0006;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid-op reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid-op reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid-op reset busy", {31'd0, busy}, 32'd0);
    chk("mid-op reset alu_x", {16'd0, alu_x}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post reset busy", {31'd0, busy}, 32'd0);
    run_op(4'd8, 16'h1234, 16'h0101, 16'h1335, 1'b0, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = 16'($urandom);
      ry  = 16'($urandom);
      m   = model(rop, rx, ry);
      run_op(rop, rx, ry, m[15:0], m[16], model_lat(rop, m[16]), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; only 16 is supported.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  operation request present.
REQ-005 SHALL have port req_ready  output  1  sequencer accepts a request.
REQ-006 SHALL have port req_op  input  4  opcode (see REQ-014).
REQ-007 SHALL have port req_x, req_y  input  16 each  operands.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-010 SHALL have port rsp_data  output  16  result; rsp_zr, rsp_ng output 1 each, zero and negative flags; rsp_err output 1, illegal opcode.
REQ-011 SHALL have port alu_x, alu_y  output  16  operands driven to the external combinational ALU.
REQ-012 SHALL have port alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits.
REQ-013 SHALL have port alu_out  input  16  ALU result; busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL decode the opcodes to control bits zx,nx,zy,ny,f,no as follows: 0 ZERO 101010, 1 ONE 111111, 2 NEG1 111010, 3 X 001100, 4 Y 110000, 5 NOTX 001101, 6 NOTY 110001, 7 NEGX 001111, 8 ADD 000010, 9 SUB(x-y) 010011, 10 AND 000000, 11 OR 010101, 12 MUL, 13-15 illegal.
REQ-015 SHALL implement the states IDLE, EXEC, MUL_ADD, MUL_DBL and DONE.
REQ-016 SHALL assert req_ready only in IDLE and accept a request on a cycle where req_valid and req_ready are both high.
REQ-017 SHALL, for a single-step op accepted at edge T, capture the operands, spend one cycle in EXEC driving the decoded control bits, register alu_out, and assert rsp_valid after edge T+2.
REQ-018 SHALL compute MUL as a 16-iteration shift-add through the ALU, with each iteration taking two cycles.
REQ-019 SHALL, in MUL_ADD, drive acc + mcand with ADD bits and update acc only if the current multiplier LSB is 1.
REQ-020 SHALL, in MUL_DBL, drive mcand + mcand with ADD bits into mcand and shift the multiplier right by one.
REQ-021 SHALL make MUL latency fixed and independent of the operand values, with rsp_valid asserted after edge T+33.
REQ-022 SHALL make the MUL result the low 16 bits of the product; overflow SHALL be discarded silently.
REQ-023 SHALL make an illegal opcode go straight to DONE, with rsp_data 0x0000, rsp_err 1, and rsp_valid after edge T+1.
REQ-024 SHALL set rsp_zr = (rsp_data == 0) and rsp_ng = rsp_data[15] for every opcode.
REQ-025 SHALL, in DONE, hold rsp_valid and all rsp_* outputs stable until rsp_ready is high, then return to IDLE on that edge.
REQ-026 SHALL ignore a req_valid that coincides with a rsp handshake, so that no request is accepted on the same edge.
REQ-027 SHALL drive the ALU outputs to 0 with control bits 101010 while in IDLE or DONE.

Reset
REQ-028 SHALL, while rst is high, immediately force the state to IDLE and all outputs to 0, except req_ready which SHALL be 1.
REQ-029 SHALL, when rst is asserted mid-MUL or in DONE, discard the operation with no response.

Configuration
REQ-030 SHALL, when ALU_SEQ_MUL_EN is defined, support opcode 12 and build MUL_ADD/MUL_DBL and the acc/mcand/multiplier registers.
REQ-031 SHALL, when ALU_SEQ_MUL_EN is undefined, treat opcode 12 as illegal (REQ-023) and instantiate no MUL state or registers.

Structure
REQ-032 SHALL place the opcode enum, the state enum and the 6-bit control-bit constants in the shared package alu_seq_pkg.
REQ-033 SHALL implement opcode-to-control decoding in the combinational sub-module alu_seq_decode (opcode in; control bits and illegal flag out).

Verification
REQ-034 SHALL cover: ADD x=0x0003 y=0x0004 -> rsp_data 0x0007, zr 0, ng 0, rsp_valid after edge T+2.
REQ-035 SHALL cover: SUB x=0x0005 y=0x0005 -> 0x0000, zr 1; then NEGX x=0x0001 -> 0xFFFF, ng 1.
REQ-036 SHALL cover: MUL x=0x0007 y=0x0006 -> 0x002A after edge T+33; and MUL x=0x8000 y=0x0002 -> 0x0000, zr 1.
REQ-037 SHALL cover: rsp_ready held low for 5 cycles after an OR of 0x00F0|0x0F00 -> 0x0FF0 held stable, req_ready 0 throughout.
REQ-038 SHALL cover: rst pulsed at cycle 10 of a MUL -> IDLE, rsp_valid 0, next ADD returns the correct result.
REQ-039 SHALL cover: opcode 15, and opcode 12 with ALU_SEQ_MUL_EN undefined -> rsp_err 1, rsp_data 0x0000 after edge T+1.
